uart_cmd_ctrl: RTL and testbench

- Command-frame controller directly downstream of the UART receiver and upstream of the UART transmitter.
- Consumes received bytes (RX parallel data/valid) and decodes write and read command frames.
- Issues single-cycle register-file accesses.
- Returns read data as one byte to the UART transmitter using a valid/busy handshake.

---
 rtl/uart_cmd_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART command frames into register-file accesses and returns read data to UART TX
//   Frames: WR_CMD,addr,data -> one-cycle reg_wr_en; RD_CMD,addr -> reg_rd_en, then read byte sent via tx_valid/tx_busy.
//   Ports: clk, rst (sync, active-high); rx_data/rx_valid/rx_err from UART RX;
//          reg_addr/reg_wr_en/reg_wr_data/reg_rd_en out and reg_rd_data/reg_rd_valid in to the register file;
//          tx_data/tx_valid out and tx_busy in to UART TX; cmd_error pulse and ctrl_busy status.
//   Optional: define UART_CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD = 8'hBB,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  cmd_error,
  output logic                  ctrl_busy
);
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ, TX_WAIT_HI, TX_WAIT_LO
  } state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wr_data_n, tx_data_n;
  logic wr_en_n, rd_en_n, tx_valid_n, err_n;
  logic in_frame, timeout;
  // Only the byte-collecting states can be aborted by a line error or a timeout.
  assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // Restarts on every received byte and on any state change, idles at zero outside frames.
  always_ff @(posedge clk)
    if (rst || !in_frame || rx_valid || state_n != state) cnt <= '0;
    else cnt <= cnt + CW'(1);
  assign timeout = in_frame && (cnt == CW'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    addr_n     = reg_addr;
    wr_data_n  = reg_wr_data;
    tx_data_n  = tx_data;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    tx_valid_n = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE:
        if (rx_valid) begin
          state_n = rx_data == WR_CMD ? WR_ADDR : rx_data == RD_CMD ? RD_ADDR : IDLE;
          err_n   = rx_data != WR_CMD && rx_data != RD_CMD;
        end
      WR_ADDR:
        if (rx_valid) begin
          addr_n  = rx_data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      WR_DATA:
        if (rx_valid) begin
          wr_data_n = rx_data;
          wr_en_n   = 1'b1;
          state_n   = IDLE;
        end
      RD_ADDR:
        if (rx_valid) begin
          addr_n  = rx_data[ADDR_WIDTH-1:0];
          rd_en_n = 1'b1;
          state_n = RD_WAIT;
        end
      RD_WAIT:
        if (reg_rd_valid) begin
          tx_data_n = reg_rd_data;
          state_n   = TX_REQ;
        end
      TX_REQ:
        if (!tx_busy) begin
          tx_valid_n = 1'b1;
          state_n    = TX_WAIT_HI;
        end
      TX_WAIT_HI: state_n = tx_busy ? TX_WAIT_LO : TX_WAIT_HI;
      TX_WAIT_LO: state_n = tx_busy ? TX_WAIT_LO : IDLE;
      default:    state_n = IDLE;
    endcase
    // A line error or timeout wins over a byte arriving in the same cycle and cancels any access.
    if (in_frame && (rx_err || timeout)) begin
      state_n   = IDLE;
      err_n     = 1'b1;
      addr_n    = reg_addr;
      wr_data_n = reg_wr_data;
      wr_en_n   = 1'b0;
      rd_en_n   = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      tx_data     <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      tx_valid    <= 1'b0;
      cmd_error   <= 1'b0;
      ctrl_busy   <= 1'b0;
    end else begin
      state       <= state_n;
      reg_addr    <= addr_n;
      reg_wr_data <= wr_data_n;
      tx_data     <= tx_data_n;
      reg_wr_en   <= wr_en_n;
      reg_rd_en   <= rd_en_n;
      tx_valid    <= tx_valid_n;
      cmd_error   <= err_n;
      ctrl_busy   <= state_n != IDLE;
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized frame checks of uart_cmd_ctrl against a frame-level model
module tb_uart_cmd_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, reg_rd_data = 0;
  logic rx_valid = 0, rx_err = 0, reg_rd_valid = 0, tx_busy = 0;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data, tx_data;
  logic reg_wr_en, reg_rd_en, tx_valid, cmd_error, ctrl_busy;
  uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .cmd_error(cmd_error), .ctrl_busy(ctrl_busy)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, s_wr, s_rd, s_tx, s_err;
  int cyc_n = 0, tx_cyc = -1, fall_cyc = -1, busy_start = -1, busy_end = -1, hold_until = 0;
  int busy_delay = 2, busy_len = 10, rd_lat = 2, rd_cnt = 0;
  bit rd_pend = 0, prev_busy = 0;
  logic [7:0] rf [16], exp_rf [16], last_wd, last_tx;
  logic [3:0] last_wa, last_ra;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock: observe outputs just after the edge and play register file and UART TX.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    reg_rd_valid = 0;
    if (reg_wr_en) begin
      n_wr++; last_wa = reg_addr; last_wd = reg_wr_data; rf[reg_addr] = reg_wr_data;
    end
    if (reg_rd_en) begin
      n_rd++; last_ra = reg_addr; rd_pend = 1; rd_cnt = rd_lat;
    end
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        reg_rd_valid = 1; reg_rd_data = rf[last_ra]; rd_pend = 0;
      end else rd_cnt--;
    end
    if (tx_valid) begin
      n_tx++; last_tx = tx_data; tx_cyc = cyc_n;
      busy_start = cyc_n + busy_delay; busy_end = busy_start + busy_len;
    end
    tx_busy = (cyc_n < hold_until) || (cyc_n >= busy_start && cyc_n < busy_end);
    if (cmd_error) n_err++;
    if (prev_busy && !ctrl_busy) fall_cyc = cyc_n;
    prev_busy = ctrl_busy;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap, input logic err, input logic vld);
    rx_data = b; rx_valid = vld; rx_err = err;
    cyc();
    rx_valid = 0; rx_err = 0;
    repeat (gap) cyc();
  endtask
  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_tx = n_tx; s_err = n_err;
  endtask
  task automatic chk_d(input string tag, input int w, input int r, input int t, input int e);
    chk({tag, "_wr"}, n_wr - s_wr, w);
    chk({tag, "_rd"}, n_rd - s_rd, r);
    chk({tag, "_tx"}, n_tx - s_tx, t);
    chk({tag, "_err"}, n_err - s_err, e);
  endtask
  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while (ctrl_busy && k < max) begin cyc(); k++; end
    chk({tag, "_idle"}, ctrl_busy, 0);
    repeat (2) cyc();
  endtask
  task automatic do_reset();
    rst = 1; rd_pend = 0; hold_until = 0; busy_start = -1; busy_end = -1;
    cyc(); cyc();
    rst = 0;
  endtask
  function automatic int gap();
    return $urandom_range(0, 3);
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int kind, k;
    logic [7:0] a, d, op;
    for (int i = 0; i < 16; i++) begin rf[i] = 8'($urandom); exp_rf[i] = rf[i]; end
    do_reset();
    chk("reset", {reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, tx_data, tx_valid, cmd_error, ctrl_busy}, 0);
    // write AA,05,3C
    snap();
    send_byte(8'hAA, 0, 0, 1); send_byte(8'h05, 0, 0, 1); send_byte(8'h3C, 0, 0, 1);
    exp_rf[5] = 8'h3C;
    chk("wr_en_now", reg_wr_en, 1);
    chk("wr_addr", reg_addr, 5);
    chk("wr_data", reg_wr_data, 8'h3C);
    chk("wr_busy", ctrl_busy, 0);
    cyc();
    chk("wr_en_once", reg_wr_en, 0);
    chk_d("wr", 1, 0, 0, 0);
    // read BB,0A returning 7E
    rf[10] = 8'h7E; exp_rf[10] = 8'h7E;
    rd_lat = 2; busy_delay = 2; busy_len = 10;
    snap();
    send_byte(8'hBB, 0, 0, 1); send_byte(8'h0A, 0, 0, 1);
    wait_idle("rd", 200);
    chk_d("rd", 0, 1, 1, 0);
    chk("rd_addr", last_ra, 4'hA);
    chk("rd_tx", last_tx, 8'h7E);
    chk("rd_fall", fall_cyc, busy_end + 1);
    // bad opcode then a normal write
    snap();
    send_byte(8'h55, 0, 0, 1);
    chk("bad_pulse", cmd_error, 1);
    cyc();
    chk("bad_once", cmd_error, 0);
    chk_d("bad", 0, 0, 0, 1);
    snap();
    send_byte(8'hAA, 1, 0, 1); send_byte(8'h01, 2, 0, 1); send_byte(8'hFF, 0, 0, 1);
    exp_rf[1] = 8'hFF;
    cyc();
    chk_d("wr2", 1, 0, 0, 0);
    chk("wr2_addr", last_wa, 1);
    chk("wr2_data", last_wd, 8'hFF);
    // rx_err with rx_valid in WR_DATA aborts
    snap();
    send_byte(8'hAA, 0, 0, 1); send_byte(8'h02, 0, 0, 1); send_byte(8'h77, 0, 1, 1);
    chk("abort_busy", ctrl_busy, 0);
    repeat (2) cyc();
    chk_d("abort", 0, 0, 0, 1);
    snap();
    send_byte(8'hBB, 0, 0, 1); send_byte(8'h02, 0, 0, 1);
    wait_idle("rd2", 200);
    chk_d("rd2", 0, 1, 1, 0);
    chk("rd2_tx", last_tx, exp_rf[2]);
    // tx_busy held high until hold_until
    rd_lat = 1;
    hold_until = cyc_n + 25;
    snap();
    send_byte(8'hBB, 0, 0, 1); send_byte(8'h03, 0, 0, 1);
    wait_idle("hold", 200);
    chk_d("hold", 0, 1, 1, 0);
    chk("hold_txcyc", tx_cyc, hold_until + 1);
    chk("hold_tx", last_tx, exp_rf[3]);
    // rx_err in IDLE ignored
    snap();
    send_byte(8'h00, 2, 1, 0);
    chk_d("idle_err", 0, 0, 0, 0);
    chk("idle_err_busy", ctrl_busy, 0);
    // byte during RD_WAIT dropped silently
    rd_lat = 8;
    snap();
    send_byte(8'hBB, 0, 0, 1); send_byte(8'h04, 0, 0, 1); send_byte(8'h55, 0, 0, 1);
    wait_idle("rdw", 200);
    chk_d("rdw", 0, 1, 1, 0);
    chk("rdw_tx", last_tx, exp_rf[4]);
    // reset mid-frame discards the partial write
    send_byte(8'hAA, 0, 0, 1); send_byte(8'h05, 0, 0, 1);
    do_reset();
    chk("mid_rst_busy", ctrl_busy, 0);
    snap();
    send_byte(8'h3C, 0, 0, 1);
    repeat (2) cyc();
    chk_d("mid_rst", 0, 0, 0, 1);
    // partial frame then silence
    snap();
    send_byte(8'hAA, 0, 0, 1);
`ifdef UART_CMD_TIMEOUT_EN
    k = 0;
    while (n_err == s_err && k < 60) begin cyc(); k++; end
    chk("to_lat", k, 17);
    chk("to_busy", ctrl_busy, 0);
    repeat (2) cyc();
    chk_d("to", 0, 0, 0, 1);
`else
    repeat (40) cyc();
    chk("to_busy", ctrl_busy, 1);
    chk_d("to", 0, 0, 0, 0);
    send_byte(8'h00, 2, 1, 0);
    chk("to_abort_busy", ctrl_busy, 0);
    chk_d("to_abort", 0, 0, 0, 1);
`endif
    // randomized frames against the frame-level model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a = 8'($urandom); d = 8'($urandom);
      rd_lat = $urandom_range(0, 4); busy_delay = $urandom_range(0, 3); busy_len = $urandom_range(1, 6);
      snap();
      if (kind == 0) begin
        send_byte(8'hAA, gap(), 0, 1); send_byte(a, gap(), 0, 1); send_byte(d, gap(), 0, 1);
        exp_rf[a[3:0]] = d;
        wait_idle("rw", 300);
        chk_d("rw", 1, 0, 0, 0);
        chk("rw_addr", last_wa, a[3:0]);
        chk("rw_data", last_wd, d);
      end else if (kind == 1) begin
        send_byte(8'hBB, gap(), 0, 1); send_byte(a, gap(), 0, 1);
        wait_idle("rr", 300);
        chk_d("rr", 0, 1, 1, 0);
        chk("rr_addr", last_ra, a[3:0]);
        chk("rr_tx", last_tx, exp_rf[a[3:0]]);
      end else if (kind == 2) begin
        do op = 8'($urandom); while (op == 8'hAA || op == 8'hBB);
        send_byte(op, gap(), 0, 1);
        wait_idle("rb", 300);
        chk_d("rb", 0, 0, 0, 1);
      end else begin
        k = $urandom_range(0, 2);
        send_byte(k == 2 ? 8'hBB : 8'hAA, gap(), 0, 1);
        if (k == 1) send_byte(a, gap(), 0, 1);
        send_byte(d, gap(), 1, 1'($urandom));
        wait_idle("ra", 300);
        chk_d("ra", 0, 0, 0, 1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
